// File: rtl/multi_motor_pwm.sv
// N-channel H-bridge PWM/direction driver; reversal coasts the bridge for DEAD_PERIODS full periods.
// Outputs registered (1 clk); cmd_ready low while any channel is in dead-time. Duty ramp: MULTI_MOTOR_RAMP_EN.
module multi_motor_pwm #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 10,
  parameter int PERIOD       = 1000,
  parameter int PRESCALE     = 50,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CHANNELS*CNT_W-1:0] duty_in,
  input  logic [CHANNELS-1:0]       dir_in,
  output logic [CHANNELS-1:0]       pwm,
  output logic [CHANNELS-1:0]       ina,
  output logic [CHANNELS-1:0]       inb,
  output logic [CHANNELS-1:0]       busy
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W = $clog2(DEAD_PERIODS + 2);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] PER      = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DC_W-1:0]  DC_PB    = DC_W'(DEAD_PERIODS);
  localparam logic [DC_W-1:0]  DC_MID   = DC_W'(DEAD_PERIODS + 1);
  localparam logic [DC_W-1:0]  DC_ONE   = DC_W'(1);

  logic [PS_W-1:0]     pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick, pb, cap;
  state_t              st_q [CHANNELS];
  state_t              st_d [CHANNELS];
  logic [CNT_W-1:0]    tgt_duty_q [CHANNELS];
  logic [CNT_W-1:0]    tgt_duty_d [CHANNELS];
  logic [CNT_W-1:0]    act_q [CHANNELS];
  logic [CNT_W-1:0]    act_d [CHANNELS];
  logic [DC_W-1:0]     dc_q [CHANNELS];
  logic [DC_W-1:0]     dc_d [CHANNELS];
  logic [CHANNELS-1:0] tgt_dir_q, tgt_dir_d, cur_dir_q, cur_dir_d;
  logic [CHANNELS-1:0] pwm_d, ina_d, inb_d, busy_d;
  logic                ready_d;
  logic [CNT_W-1:0]    duty_clamp, run_duty, exit_duty;

`ifdef MULTI_MOTOR_RAMP_EN
  localparam logic [CNT_W:0] STEP = (CNT_W + 1)'(RAMP_STEP);

  // Move cur toward tgt by at most STEP, landing exactly on tgt.
  function automatic logic [CNT_W-1:0] ramp_to(input logic [CNT_W-1:0] cur,
                                               input logic [CNT_W-1:0] tgt);
    logic [CNT_W:0] c, t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c) ramp_to = ((t - c) > STEP) ? CNT_W'(c + STEP) : tgt;
    else       ramp_to = ((c - t) > STEP) ? CNT_W'(c - STEP) : tgt;
  endfunction
`endif

  always_comb begin
    tick    = (pre_q == PS_LAST);
    pb      = tick && (cnt_q == PER_LAST);
    cap     = cmd_valid && cmd_ready;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    cnt_d   = cnt_q;
    if (tick) cnt_d = pb ? '0 : cnt_q + 1'b1;
    ready_d    = 1'b1;
    pwm_d      = '0;
    ina_d      = '0;
    inb_d      = '0;
    busy_d     = '0;
    tgt_dir_d  = tgt_dir_q;
    cur_dir_d  = cur_dir_q;
    duty_clamp = '0;
    run_duty   = '0;
    exit_duty  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      duty_clamp = duty_in[k*CNT_W +: CNT_W];
      if (duty_clamp > PER) duty_clamp = PER;
`ifdef MULTI_MOTOR_RAMP_EN
      run_duty  = ramp_to(act_q[k], tgt_duty_q[k]);
      exit_duty = ramp_to('0, tgt_duty_q[k]);
`else
      run_duty  = tgt_duty_q[k];
      exit_duty = tgt_duty_q[k];
`endif
      st_d[k]       = st_q[k];
      act_d[k]      = act_q[k];
      dc_d[k]       = dc_q[k];
      tgt_duty_d[k] = cap ? duty_clamp : tgt_duty_q[k];
      tgt_dir_d[k]  = cap ? dir_in[k] : tgt_dir_q[k];
      case (st_q[k])
        IDLE: begin
          if (cap) begin
            st_d[k]      = RUN;
            cur_dir_d[k] = dir_in[k];
          end
        end
        RUN: begin
          if (pb) act_d[k] = run_duty;
          // A pb landing on entry already starts a full period, so it needs one fewer pb.
          if (cap && (dir_in[k] != cur_dir_q[k])) begin
            st_d[k]  = DEAD;
            act_d[k] = '0;
            dc_d[k]  = pb ? DC_PB : DC_MID;
          end
        end
        DEAD: begin
          act_d[k] = '0;
          if (pb) begin
            if (dc_q[k] == DC_ONE) begin
              st_d[k]      = RUN;
              cur_dir_d[k] = tgt_dir_q[k];
              act_d[k]     = exit_duty;
            end else begin
              dc_d[k] = dc_q[k] - 1'b1;
            end
          end
        end
        default: st_d[k] = IDLE;
      endcase
      pwm_d[k]  = (st_d[k] == RUN) && (cnt_q < act_q[k]);
      ina_d[k]  = (st_d[k] == RUN) && cur_dir_d[k];
      inb_d[k]  = (st_d[k] == RUN) && !cur_dir_d[k];
      busy_d[k] = (st_d[k] == DEAD);
      if (st_d[k] == DEAD) ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      tgt_dir_q <= '0;
      cur_dir_q <= '0;
      pwm       <= '0;
      ina       <= '0;
      inb       <= '0;
      busy      <= '0;
      cmd_ready <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        st_q[k]       <= IDLE;
        tgt_duty_q[k] <= '0;
        act_q[k]      <= '0;
        dc_q[k]       <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      tgt_dir_q <= tgt_dir_d;
      cur_dir_q <= cur_dir_d;
      pwm       <= pwm_d;
      ina       <= ina_d;
      inb       <= inb_d;
      busy      <= busy_d;
      cmd_ready <= ready_d;
      for (int k = 0; k < CHANNELS; k++) begin
        st_q[k]       <= st_d[k];
        tgt_duty_q[k] <= tgt_duty_d[k];
        act_q[k]      <= act_d[k];
        dc_q[k]       <= dc_d[k];
      end
    end
  end

endmodule

// File: tb/tb_multi_motor_pwm.sv
// Bench for multi_motor_pwm: random commands checked against a period-arithmetic reference model.
module tb_multi_motor_pwm;
  localparam int CH  = 2;
  localparam int CW  = 10;
  localparam int PER = 10;
  localparam int PS  = 2;
  localparam int DP  = 2;
  localparam int RS  = 2;
  localparam int T   = PER * PS;
`ifdef MULTI_MOTOR_RAMP_EN
  localparam int STEP = RS;
`else
  localparam int STEP = PER;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [CH*CW-1:0] duty_in = '0;
  logic [CH-1:0] dir_in = '0;
  logic [CH-1:0] pwm, ina, inb, busy;

  int n_cmp = 0;
  int n_bad = 0;

  multi_motor_pwm #(
    .CHANNELS(CH), .CNT_W(CW), .PERIOD(PER), .PRESCALE(PS),
    .DEAD_PERIODS(DP), .RAMP_STEP(RS)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .duty_in(duty_in), .dir_in(dir_in), .pwm(pwm), .ina(ina), .inb(inb), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: time is the count of clock edges since reset; cnt and period
  // boundaries follow from division, dead-time end is computed as an absolute edge.
  int m_n;
  int m_mode  [CH];
  int m_act   [CH];
  int m_tduty [CH];
  int m_dir   [CH];
  int m_tdir  [CH];
  int m_exit  [CH];
  logic [CH-1:0] e_pwm, e_ina, e_inb, e_busy;
  logic e_ready;

  function automatic int approach(input int cur, input int tgt);
    if (tgt > cur) return ((tgt - cur) > STEP) ? cur + STEP : tgt;
    return ((cur - tgt) > STEP) ? cur - STEP : tgt;
  endfunction

  always @(posedge clk) begin : model
    int cnt_prev, d, act_old;
    bit pb, cap;
    if (rst) begin
      m_n = 0;
      for (int k = 0; k < CH; k++) begin
        m_mode[k] = M_IDLE; m_act[k] = 0; m_tduty[k] = 0;
        m_dir[k] = 0; m_tdir[k] = 0; m_exit[k] = 0;
      end
      e_pwm = '0; e_ina = '0; e_inb = '0; e_busy = '0; e_ready = 1'b1;
    end else begin
      cnt_prev = (m_n / PS) % PER;
      m_n = m_n + 1;
      pb  = (m_n % T) == 0;
      cap = cmd_valid && e_ready;
      for (int k = 0; k < CH; k++) begin
        act_old = m_act[k];
        d = int'(duty_in[k*CW +: CW]);
        if (d > PER) d = PER;
        if (m_mode[k] == M_IDLE) begin
          if (cap) begin m_mode[k] = M_RUN; m_dir[k] = int'(dir_in[k]); end
        end else if (m_mode[k] == M_RUN) begin
          if (pb) m_act[k] = approach(m_act[k], m_tduty[k]);
          if (cap && (int'(dir_in[k]) != m_dir[k])) begin
            m_mode[k] = M_DEAD;
            m_act[k]  = 0;
            m_exit[k] = ((m_n + T - 1) / T) * T + DP * T;
          end
        end else begin
          m_act[k] = 0;
          if (m_n == m_exit[k]) begin
            m_mode[k] = M_RUN;
            m_dir[k]  = m_tdir[k];
            m_act[k]  = approach(0, m_tduty[k]);
          end
        end
        if (cap) begin m_tduty[k] = d; m_tdir[k] = int'(dir_in[k]); end
        e_pwm[k]  = (m_mode[k] == M_RUN) && (cnt_prev < act_old);
        e_ina[k]  = (m_mode[k] == M_RUN) && (m_dir[k] == 1);
        e_inb[k]  = (m_mode[k] == M_RUN) && (m_dir[k] == 0);
        e_busy[k] = (m_mode[k] == M_DEAD);
      end
      e_ready = (e_busy == '0);
    end
  end

  task automatic set_cmd(input int d0, input int r0, input int d1, input int r1);
    duty_in[0 +: CW]  = CW'(d0);
    duty_in[CW +: CW] = CW'(d1);
    dir_in    = {1'(r1), 1'(r0)};
    cmd_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; duty_in = '0; dir_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pwm, ina, inb, busy, cmd_ready} !== {{(4*CH){1'b0}}, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_hold: pwm=%b ina=%b inb=%b busy=%b rdy=%b, required zeros and rdy=1",
               pwm, ina, inb, busy, cmd_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({pwm, ina, inb, busy, cmd_ready} !== {{(4*CH){1'b0}}, 1'b1}) begin
        n_bad++;
        $display("FAIL idle cyc %0d: pwm=%b ina=%b inb=%b busy=%b rdy=%b, required zeros and rdy=1",
                 i, pwm, ina, inb, busy, cmd_ready);
      end
    end
  endtask

  task automatic test_run();
    int highs;
    set_cmd(3, 1, $urandom_range(PER + 5, 0), $urandom_range(1, 0));
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (ina[0] !== 1'b1 || inb[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL run_dir: ina0=%b inb0=%b, required 1 0", ina[0], inb[0]);
    end
    highs = 0;
    for (int i = 0; i < 4*T; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({pwm, ina, inb, busy, cmd_ready} !== {e_pwm, e_ina, e_inb, e_busy, e_ready}) begin
        n_bad++;
        $display("FAIL run cyc %0d: got %b %b %b %b %b, required %b %b %b %b %b", i,
                 pwm, ina, inb, busy, cmd_ready, e_pwm, e_ina, e_inb, e_busy, e_ready);
      end
      if (i >= 2*T && i < 3*T && pwm[0] === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 3*PS) begin
      n_bad++;
      $display("FAIL run_highs: pwm0 high %0d of %0d clk, required %0d", highs, T, 3*PS);
    end
  endtask

  task automatic test_extremes();
    int glitches;
    glitches = 0;
    set_cmd(0, m_dir[0], 15, m_dir[1]);
    for (int i = 0; i < 11*T; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      n_cmp++;
      if ({pwm, ina, inb, busy, cmd_ready} !== {e_pwm, e_ina, e_inb, e_busy, e_ready}) begin
        n_bad++;
        $display("FAIL extremes cyc %0d: got %b %b %b %b %b, required %b %b %b %b %b", i,
                 pwm, ina, inb, busy, cmd_ready, e_pwm, e_ina, e_inb, e_busy, e_ready);
      end
      if (i > 5*T && (pwm[0] !== 1'b0 || pwm[1] !== 1'b1)) glitches++;
    end
    n_cmp++;
    if (glitches != 0) begin
      n_bad++;
      $display("FAIL extremes_const: %0d cycles off level, required 0", glitches);
    end
  endtask

  task automatic test_random();
    int wait_c;
    for (int it = 0; it < 25; it++) begin
      wait_c = $urandom_range(2*T, 1);
      for (int i = 0; i < wait_c; i++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if ({pwm, ina, inb, busy, cmd_ready} !== {e_pwm, e_ina, e_inb, e_busy, e_ready}) begin
          n_bad++;
          $display("FAIL random it %0d: got %b %b %b %b %b, required %b %b %b %b %b", it,
                   pwm, ina, inb, busy, cmd_ready, e_pwm, e_ina, e_inb, e_busy, e_ready);
        end
      end
      set_cmd($urandom_range(15, 0), $urandom_range(1, 0),
              $urandom_range(15, 0), $urandom_range(1, 0));
    end
    for (int i = 0; i < 4*T; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      n_cmp++;
      if ({pwm, ina, inb, busy, cmd_ready} !== {e_pwm, e_ina, e_inb, e_busy, e_ready}) begin
        n_bad++;
        $display("FAIL random drain %0d: got %b %b %b %b %b, required %b %b %b %b %b", i,
                 pwm, ina, inb, busy, cmd_ready, e_pwm, e_ina, e_inb, e_busy, e_ready);
      end
    end
  endtask

  task automatic test_reversal();
    bit done;
    int w;
    logic nd;
    done = 1'b0;
    for (w = 0; w < 4*T && !done; w++) begin
      @(negedge clk);
      done = (cmd_ready === 1'b1) && e_ready;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL rev_ready_wait: cmd_ready=%b after %0d clk, required 1", cmd_ready, w);
    end
    nd = (m_dir[0] == 0);
    set_cmd(6, int'(nd), m_tduty[1], m_dir[1]);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({pwm[0], ina[0], inb[0], busy[0], cmd_ready} !== 5'b00010) begin
      n_bad++;
      $display("FAIL rev_enter: pwm/ina/inb/busy/rdy=%b, required 00010",
               {pwm[0], ina[0], inb[0], busy[0], cmd_ready});
    end
    done = 1'b0;
    for (w = 0; w < 4*T && !done; w++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      n_cmp++;
      if ({pwm, ina, inb, busy, cmd_ready} !== {e_pwm, e_ina, e_inb, e_busy, e_ready}) begin
        n_bad++;
        $display("FAIL rev_dead cyc %0d: got %b %b %b %b %b, required %b %b %b %b %b", w,
                 pwm, ina, inb, busy, cmd_ready, e_pwm, e_ina, e_inb, e_busy, e_ready);
      end
      done = (busy[0] === 1'b0);
      if (w == 3) set_cmd(9, int'(!nd), 2, 1 - m_dir[1]);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL rev_exit_timeout: busy0=%b after %0d clk, required 0", busy[0], w);
    end
    n_cmp++;
    if (ina[0] !== nd || inb[0] !== !nd) begin
      n_bad++;
      $display("FAIL rev_dir: ina0=%b inb0=%b, required %b %b", ina[0], inb[0], nd, !nd);
    end
    for (int i = 0; i < 2*T; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({pwm, ina, inb, busy, cmd_ready} !== {e_pwm, e_ina, e_inb, e_busy, e_ready}) begin
        n_bad++;
        $display("FAIL rev_resume cyc %0d: got %b %b %b %b %b, required %b %b %b %b %b", i,
                 pwm, ina, inb, busy, cmd_ready, e_pwm, e_ina, e_inb, e_busy, e_ready);
      end
    end
  endtask

  task automatic test_reset_mid_dead();
    set_cmd(4, 1 - m_dir[0], m_tduty[1], m_dir[1]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    n_cmp++;
    if (busy[0] !== 1'b1 || busy[0] !== e_busy[0]) begin
      n_bad++;
      $display("FAIL mid_dead_busy: busy0=%b model=%b, required 1", busy[0], e_busy[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pwm, ina, inb, busy, cmd_ready} !== {{(4*CH){1'b0}}, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_dead_reset: pwm=%b ina=%b inb=%b busy=%b rdy=%b, required zeros and rdy=1",
               pwm, ina, inb, busy, cmd_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 2*T; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({pwm, ina, inb, busy, cmd_ready} !== {e_pwm, e_ina, e_inb, e_busy, e_ready}) begin
        n_bad++;
        $display("FAIL post_reset cyc %0d: got %b %b %b %b %b, required %b %b %b %b %b", i,
                 pwm, ina, inb, busy, cmd_ready, e_pwm, e_ina, e_inb, e_busy, e_ready);
      end
    end
  endtask

`ifdef MULTI_MOTOR_RAMP_EN
  task automatic test_ramp();
    int steps [4] = '{2, 4, 6, 7};
    int highs;
    bit aligned;
    set_cmd(0, 1, 0, 1);
    repeat (2*T) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    set_cmd(7, 1, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    aligned = 1'b0;
    for (int w = 0; w < T + 2 && !aligned; w++) begin
      @(negedge clk);
      aligned = (m_n % T) == 0;
    end
    for (int p = 0; p < 4; p++) begin
      highs = 0;
      for (int i = 0; i < T; i++) begin
        @(negedge clk);
        if (pwm[0] === 1'b1) highs++;
      end
      n_cmp++;
      if (highs != steps[p] * PS) begin
        n_bad++;
        $display("FAIL ramp period %0d: pwm0 high %0d clk, required %0d", p, highs, steps[p] * PS);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_extremes();
    test_random();
    test_reversal();
    test_reset_mid_dead();
`ifdef MULTI_MOTOR_RAMP_EN
    test_ramp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_motor_pwm.md
# multi_motor_pwm

Parametrised N-channel motor PWM and direction controller that generalises the current hard-wired dual-motor PWM. It generates one PWM output and an H-bridge direction pair (ina/inb) per channel from a shared prescaled time base. Each channel has its own duty and direction setpoint. On a direction reversal the bridge is coasted through a dead-time, and an optional duty ramp is available. The block sits between the top-level command logic and the GPIO pins driving the motor bridges.

## Interface
Parameters:
- CHANNELS, 2, number of independent motor channels (1..8)
- CNT_W, 10, width of PWM counter and duty values
- PERIOD, 1000, PWM period in ticks; must be ≤ 2^CNT_W − 1
- PRESCALE, 50, clk cycles per PWM tick (≥ 1)
- DEAD_PERIODS, 2, full PWM periods of coast on direction reversal (≥ 1)
- RAMP_STEP, 50, duty increment/decrement per period when ramping

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command strobe; captures all setpoints when cmd_ready is high
- cmd_ready  out  1  high when no channel is in dead-time
- duty_in  in  CHANNELS*CNT_W  target duties; channel k occupies bits [k*CNT_W +: CNT_W]
- dir_in  in  CHANNELS  target directions; 1 = forward (ina=1, inb=0)
- pwm  out  CHANNELS  PWM enable per channel
- ina  out  CHANNELS  bridge input A
- inb  out  CHANNELS  bridge input B
- busy  out  CHANNELS  channel in dead-time

## Operation
- Prescaler counts 0..PRESCALE−1 and asserts tick for one clk when it wraps.
- A shared period counter cnt advances on each tick over 0..PERIOD−1 and wraps to 0. The wrap point is the period boundary (pb).
- Per channel registers: tgt_duty, tgt_dir, act_duty, cur_dir, and state ∈ {IDLE, RUN, DEAD}.
- Command capture occurs when cmd_valid && cmd_ready: tgt_duty and tgt_dir load for every channel. Duties above PERIOD clamp to PERIOD.
- IDLE (after reset): ina=inb=0, pwm=0. On capture → RUN with cur_dir=tgt_dir. No dead-time is applied.
- RUN: ina=cur_dir, inb=~cur_dir, pwm = (cnt < act_duty).
  - At each pb, act_duty ← tgt_duty, so duty changes are glitch-free.
  - On capture with tgt_dir ≠ cur_dir → DEAD.
- DEAD: pwm=0, ina=inb=0, busy=1, act_duty ← 0. The state remains for DEAD_PERIODS complete periods, counted on pb; the partial period at entry does not count. It then → RUN with cur_dir=tgt_dir, and act_duty loads at that same pb.
- Duty 0 gives pwm constantly low. Duty PERIOD gives pwm constantly high with no glitch at wrap.
- cmd_valid while cmd_ready is low is ignored; there is no queueing.
- Reset mid-operation: all state returns to reset values on the next clk edge, regardless of state.

## Timing
- Reset values: pwm=0, ina=0, inb=0, busy=0, cmd_ready=1, cnt=0, prescaler=0, act_duty=0, state=IDLE.
- All outputs are registered. pwm reflects cnt/act_duty with 1 clk latency after the cnt update.
- Capture to RUN ina/inb change from IDLE: 1 clk.
- Capture to DEAD (pwm=0, ina=inb=0, busy=1, cmd_ready=0): 1 clk.
- A new duty in RUN takes effect at the first pb after capture.
- A capture coinciding with pb: act_duty takes the old tgt_duty at that pb and the new value at the next pb.
- DEAD exit and RUN pwm resume occur in the same clk as the final counted pb.

## Configuration
- MULTI_MOTOR_RAMP_EN defined: at each pb in RUN, act_duty moves toward tgt_duty by at most RAMP_STEP and saturates at the target without overshoot. On exit from DEAD, act_duty starts at 0 and ramps up.
- Undefined: act_duty ← tgt_duty directly at pb, and RAMP_STEP is unused.

## Test plan
- Parameters for all scenarios: PERIOD=10, PRESCALE=2, DEAD_PERIODS=2, CHANNELS=2.
- Reset, then idle 100 clk → pwm=0, ina=inb=0, cmd_ready=1.
- Command duty0=3, dir0=1 → ina0=1, inb0=0 after 1 clk. From the first pb, pwm0 is high 3 ticks of 10 (6 clk high / 20 clk).
- Duty 0 and duty 15 (clamped to 10) → pwm constantly 0 and constantly 1 respectively, with no glitch across 5 wraps.
- In RUN with dir=1, command dir=0 → after 1 clk ina=inb=0, pwm=0, busy=1, cmd_ready=0. After 2 full periods, ina=0, inb=1, duty resumes. A cmd_valid pulse during DEAD is ignored.
- Apply rst mid-DEAD → all outputs at reset values 1 clk later, and cmd_ready=1.
- With MULTI_MOTOR_RAMP_EN, RAMP_STEP=2, duty 0→7 → act_duty steps 2, 4, 6, 7 on successive pb.
